// File: rtl/alu_issue_ctrl_if.sv
// Handshake and datapath bundle between the issue controller, its
// instruction/load sources, the downstream result consumer and the ALU.
interface alu_issue_ctrl_if #(
  parameter int DW   = 16,
  parameter int NREG = 8
);
  localparam int AW = $clog2(NREG);

  // Instruction channel
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;

  // Direct register-load channel
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  // ALU operand/result bus
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_zero;

  // Result channel and status
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_rd;
  logic          z_flag;
  logic [15:0]   op_count;

  // Controller side
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    output in_ready,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_zero,
    output out_valid, out_data, out_rd, z_flag, op_count,
    input  out_ready
  );

  // Environment side
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  in_ready,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_zero,
    input  out_valid, out_data, out_rd, z_flag, op_count,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback controller for a combinational ALU.
// Holds an NREG x DW register file (r0 hard-wired to zero), issues one
// instruction at a time through IDLE -> READ -> EXEC -> WB, and retires
// the result back into the register file once downstream accepts it.
module alu_issue_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input logic           clk,
  input logic           rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state;
  logic [DW-1:0] regs [NREG];
  logic [3:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic [3:0]    alu_sel_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          zero_pend;
  logic          z_q;
  logic [15:0]   count_q;

  // Handshake readiness follows the state; a load wins over an instruction.
  assign bus.ld_ready  = (state == IDLE);
  assign bus.in_ready  = (state == IDLE) && !bus.ld_valid;

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_rd    = rd_q;
  assign bus.z_flag    = z_q;
  assign bus.op_count  = count_q;

  // Issue FSM, register file and all registered outputs.
  // NOTE: every register here is updated with <= so all reads in a cycle
  // see pre-edge values (e.g. READ samples sources before WB could write).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      zero_pend   <= 1'b0;
      z_q         <= 1'b0;
      count_q     <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it
      // is reset here as flops rather than left as an uninitialised RAM.
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ld_valid) begin
            if (bus.ld_addr != '0) regs[bus.ld_addr] <= bus.ld_data;
          end else if (bus.in_valid) begin
            op_q  <= bus.in_op;
            rd_q  <= bus.in_rd;
            rs1_q <= bus.in_rs1;
            rs2_q <= bus.in_rs2;
            state <= READ;
          end
        end
        READ: begin
          // r0 is never written, so it always reads back as zero.
          alu_a_q   <= regs[rs1_q];
          alu_b_q   <= regs[rs2_q];
          alu_sel_q <= op_q;
          state     <= EXEC;
        end
        EXEC: begin
          out_data_q  <= bus.alu_out;
          zero_pend   <= bus.alu_zero;
          out_valid_q <= 1'b1;
          state       <= WB;
        end
        WB: begin
          if (bus.out_ready) begin
            if (rd_q != '0) regs[rd_q] <= out_data_q;
            z_q         <= zero_pend;
            count_q     <= count_q + 16'd1;
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
